psum_drain: RTL and testbench
=============================

PSUM_DRAIN -- requirements
Module: psum_drain

Interface
REQ-001 Parameter col, default 8, number of psum lanes per row.
REQ-002 Parameter psum_bw, default 16, bits per signed psum lane.
REQ-003 Parameter addr_bw, default 11, psum SRAM address width.
REQ-004 clk  input  1  single clock; all state updates on rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle pulse that launches a drain job; sampled only in IDLE.
REQ-007 len  input  addr_bw  rows to drain; latched on accepted start.
REQ-008 base  input  addr_bw  first SRAM row address; latched on accepted start.
REQ-009 acc  input  1  1 = read-add-write into SRAM, 0 = overwrite; latched on start.
REQ-010 relu  input  1  1 = clamp negative lanes to 0 before write; latched on start.
REQ-011 ofifo_valid  input  1  output FIFO holds at least one complete row.
REQ-012 ofifo_out  input  col*psum_bw  head row of FIFO, lane i at bits [(i+1)*psum_bw-1 : i*psum_bw].
REQ-013 ofifo_rd  output  1  pop strobe; head row is consumed at the clock edge where it is high.
REQ-014 sram_cen / sram_wen  output  1 each  active-low chip enable / write enable.
REQ-015 sram_addr  output  addr_bw  SRAM row address.
REQ-016 sram_d  output  col*psum_bw  SRAM write data.
REQ-017 sram_q  input  col*psum_bw  SRAM read data, valid one cycle after a read request.
REQ-018 busy / done  output  1 each  busy high outside IDLE; done is a one-cycle pulse at job end.

Function
REQ-019 FSM states SHALL be IDLE, WAIT, RD, ACC, WR, DONE.
REQ-020 IDLE: start=1 latches len/base/acc/relu, clears row count, and goes to DONE if len=0, else to WAIT.
REQ-021 WAIT: if ofifo_valid=1, assert ofifo_rd for exactly that cycle, register ofifo_out, and go to RD (acc=1) or WR (acc=0); otherwise stay, with ofifo_rd=0.
REQ-022 RD: cen=0, wen=1, addr=current address; next state ACC.
REQ-023 ACC: data lane i <= data lane i + sram_q lane i, two's-complement, truncated to psum_bw (wrap, no saturation); next state WR.
REQ-024 WR: cen=0, wen=0, addr=current address, d=data with ReLU applied per lane when relu=1.
REQ-025 WR exit: increment address and row count; go to DONE when count reaches len, else to WAIT.
REQ-026 DONE: done=1 for one cycle, then IDLE.
REQ-027 Address SHALL wrap modulo 2^addr_bw past the all-ones address.
REQ-028 Outside RD/WR, cen=1 and wen=1; sram_addr and sram_d hold their last values.
REQ-029 ofifo_rd SHALL never assert outside WAIT, nor when ofifo_valid=0.
REQ-030 start while busy=1 SHALL be ignored.
REQ-031 Throughput: 2 cycles per row (acc=0) and 4 cycles per row (acc=1) when ofifo_valid stays high.
REQ-032 Job latency: start to done = 2 + len*2 cycles (acc=0) or 2 + len*4 cycles (acc=1), given a continuously valid FIFO.

Reset
REQ-033 reset=1 SHALL force IDLE; ofifo_rd=0, cen=1, wen=1, busy=0, done=0, and address, count and data registers = 0.
REQ-034 Reset mid-job SHALL abort with no further pop or SRAM access; a write already issued in that cycle is not retracted.

Structure
REQ-035 Shared package SHALL hold the FSM state encoding and the default col/psum_bw/addr_bw constants.
REQ-036 Sub-module psum_lane (one psum_bw add with wrap, plus optional ReLU) SHALL be instantiated col times by generate.

Verification
REQ-037 acc=0, relu=0, len=3, base=5, FIFO holds rows R0..R2 -> SRAM 5,6,7 = R0,R1,R2; exactly 3 pops; done at cycle 8 after start.
REQ-038 acc=1, len=1, base=0, SRAM[0] lane0 = 100, FIFO lane0 = -30 -> SRAM[0] lane0 = 70; lane0 = 0x7FFF + 1 -> 0x8000 (wrap).
REQ-039 relu=1, acc=0, row lanes {-1, 5, -32768, 0, ...} -> written {0, 5, 0, 0, ...}.
REQ-040 len=0 start -> done on cycle 2 after start; no pop, no SRAM access.
REQ-041 ofifo_valid low for 10 cycles in WAIT, then high -> FSM holds WAIT, ofifo_rd=0 throughout, pop on the first valid cycle.
REQ-042 base=2047, len=2, addr_bw=11 -> writes to 2047 then 0; reset asserted in WAIT of the second row -> IDLE next cycle, no second pop.

Source files
------------

// File: rtl/psum_drain_pkg.sv
// psum_drain shared package
// State encoding and default geometry for the psum drain engine.
package psum_drain_pkg;

  localparam int def_col     = 8;
  localparam int def_psum_bw = 16;
  localparam int def_addr_bw = 11;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_WAIT = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_ACC  = 3'd3;
  localparam logic [2:0] S_WR   = 3'd4;
  localparam logic [2:0] S_DONE = 3'd5;

endpackage

// File: rtl/psum_drain_lane.sv
// psum_lane: one psum lane
// Optional wrap-around add of the SRAM value, then optional ReLU.
module psum_lane #(
  parameter int psum_bw = 16
) (
  input  logic [psum_bw-1:0] a,
  input  logic [psum_bw-1:0] b,
  input  logic               add_en,
  input  logic               relu_en,
  output logic [psum_bw-1:0] sum,
  output logic [psum_bw-1:0] res
);

  // two's-complement add, carry out is dropped
  assign sum = add_en ? a + b : a;

  // negative lanes clamp to zero when relu is on
  assign res = (relu_en && sum[psum_bw-1]) ? '0 : sum;

endmodule

// File: rtl/psum_drain.sv
// psum_drain: moves rows from the output FIFO into psum SRAM
// Rows are either overwritten or accumulated onto the stored row.
module psum_drain
  import psum_drain_pkg::*;
#(
  parameter int col     = def_col,
  parameter int psum_bw = def_psum_bw,
  parameter int addr_bw = def_addr_bw
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic [addr_bw-1:0]       len,
  input  logic [addr_bw-1:0]       base,
  input  logic                     acc,
  input  logic                     relu,
  input  logic                     ofifo_valid,
  input  logic [col*psum_bw-1:0]   ofifo_out,
  output logic                     ofifo_rd,
  output logic                     sram_cen,
  output logic                     sram_wen,
  output logic [addr_bw-1:0]       sram_addr,
  output logic [col*psum_bw-1:0]   sram_d,
  input  logic [col*psum_bw-1:0]   sram_q,
  output logic                     busy,
  output logic                     done
);

  localparam logic [addr_bw-1:0] one = {{(addr_bw-1){1'b0}}, 1'b1};

  logic [2:0]               state;
  logic [2:0]               nxt;
  logic [addr_bw-1:0]       len_q;
  logic [addr_bw-1:0]       addr_q;
  logic [addr_bw-1:0]       cnt_q;
  logic [addr_bw-1:0]       cnt_nx;
  logic                     acc_q;
  logic                     relu_q;
  logic                     last_row;
  logic                     add_en;
  logic [col*psum_bw-1:0]   data_q;
  logic [col*psum_bw-1:0]   lane_a;
  logic [col*psum_bw-1:0]   sum_w;
  logic [col*psum_bw-1:0]   res_w;

  assign cnt_nx   = cnt_q + one;
  assign last_row = (cnt_nx == len_q);
  assign busy     = (state != S_IDLE);
  assign add_en   = (state == S_ACC);
  assign lane_a   = (state == S_WAIT) ? ofifo_out : data_q;
  assign ofifo_rd = !reset && (state == S_WAIT) && ofifo_valid;

  for (genvar i = 0; i < col; i++) begin : g_lane
    psum_lane #(
      .psum_bw(psum_bw)
    ) u_lane (
      .a      (lane_a[i*psum_bw +: psum_bw]),
      .b      (sram_q[i*psum_bw +: psum_bw]),
      .add_en (add_en),
      .relu_en(relu_q),
      .sum    (sum_w[i*psum_bw +: psum_bw]),
      .res    (res_w[i*psum_bw +: psum_bw])
    );
  end

  // next-state decode
  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE: if (start) nxt = (len == '0) ? S_DONE : S_WAIT;
      S_WAIT: if (ofifo_valid) nxt = acc_q ? S_RD : S_WR;
      S_RD:   nxt = S_ACC;
      S_ACC:  nxt = S_WR;
      S_WR:   nxt = last_row ? S_DONE : S_WAIT;
      S_DONE: nxt = S_IDLE;
      default: nxt = S_IDLE;
    endcase
  end

  // state, job registers and registered SRAM port
  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= S_IDLE;
      len_q     <= '0;
      addr_q    <= '0;
      cnt_q     <= '0;
      acc_q     <= 1'b0;
      relu_q    <= 1'b0;
      data_q    <= '0;
      sram_cen  <= 1'b1;
      sram_wen  <= 1'b1;
      sram_addr <= '0;
      sram_d    <= '0;
      done      <= 1'b0;
    end else begin
      state    <= nxt;
      done     <= (state == S_DONE);
      sram_cen <= !((nxt == S_RD) || (nxt == S_WR));
      sram_wen <= !(nxt == S_WR);
      if ((nxt == S_RD) || (nxt == S_WR))
        sram_addr <= addr_q;
      if (nxt == S_WR)
        sram_d <= res_w;
      unique case (state)
        S_IDLE: begin
          if (start) begin
            len_q  <= len;
            addr_q <= base;
            acc_q  <= acc;
            relu_q <= relu;
            cnt_q  <= '0;
          end
        end
        S_WAIT: if (ofifo_valid) data_q <= sum_w;
        S_ACC:  data_q <= sum_w;
        S_WR: begin
          addr_q <= addr_q + one;
          cnt_q  <= cnt_nx;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_psum_drain.sv
// tb_psum_drain: table of drain jobs plus hand-written corner sequences
// Behavioural FIFO and SRAM models surround the DUT.
module tb_psum_drain;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         start = 1'b0;
  logic [10:0]  len = '0;
  logic [10:0]  base = '0;
  logic         acc = 1'b0;
  logic         relu = 1'b0;
  logic         ofifo_valid;
  logic [127:0] ofifo_out;
  logic         ofifo_rd;
  logic         sram_cen;
  logic         sram_wen;
  logic [10:0]  sram_addr;
  logic [127:0] sram_d;
  logic [127:0] sram_q = '0;
  logic         busy;
  logic         done;

  psum_drain dut (
    .clk(clk), .reset(reset), .start(start), .len(len), .base(base),
    .acc(acc), .relu(relu), .ofifo_valid(ofifo_valid),
    .ofifo_out(ofifo_out), .ofifo_rd(ofifo_rd), .sram_cen(sram_cen),
    .sram_wen(sram_wen), .sram_addr(sram_addr), .sram_d(sram_d),
    .sram_q(sram_q), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  logic [127:0] fifo [64];
  int           head = 0;
  int           tail = 0;
  logic         vgate = 1'b0;
  logic [127:0] mem [2048];
  int           pops = 0;
  int           writes = 0;
  int           reads = 0;
  int           wr_log [8];
  logic         pk_en = 1'b0;
  int           pk_a = 0;
  logic [127:0] pk_d = '0;
  int           total = 0;
  int           bad = 0;

  assign ofifo_valid = vgate && (tail != head);
  assign ofifo_out   = fifo[head % 64];

  always @(posedge clk) begin
    if (pk_en) mem[pk_a] = pk_d;
    if (ofifo_rd) begin
      head <= head + 1;
      pops++;
    end
    if (!sram_cen && !sram_wen) begin
      mem[sram_addr] = sram_d;
      wr_log[writes % 8] = int'(sram_addr);
      writes++;
    end else if (!sram_cen) begin
      sram_q <= mem[sram_addr];
      reads++;
    end
  end

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [127:0] row);
    fifo[tail % 64] = row;
    tail++;
  endtask

  task automatic poke(input int a, input logic [127:0] v);
    @(negedge clk);
    pk_en = 1'b1; pk_a = a; pk_d = v;
    @(negedge clk);
    pk_en = 1'b0;
  endtask

  task automatic run_job(input logic a, input logic r, input int l,
                         input int b, output int lat);
    @(negedge clk);
    acc = a; relu = r; len = 11'(l); base = 11'(b); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 1;
    while (!done && lat < 200) begin
      @(posedge clk); #1;
      lat++;
    end
    if (!done) lat = -1;
  endtask

  typedef struct {
    logic         acc;
    logic         relu;
    int           base;
    int           len;
    logic [127:0] row;
    logic [127:0] pre;
    logic [127:0] exp;
    int           lat;
  } vec_t;

  vec_t vt [6];

  localparam logic [127:0] junk = 128'hDEADBEEF_DEADBEEF_DEADBEEF_DEADBEEF;
  localparam logic [127:0] ra = {16'h7000, 16'h0600, 16'h0050, 16'h0004,
                                 16'hFFFF, 16'h8000, 16'h1234, 16'hABCD};
  localparam logic [127:0] rb = {16'h0000, 16'h0000, 16'h0000, 16'h0010,
                                 16'h8000, 16'hFFFF, 16'h7FFF, 16'hFFE2};
  localparam logic [127:0] pb = {16'h0000, 16'h0000, 16'h0000, 16'h0020,
                                 16'h8000, 16'hFFFF, 16'h0001, 16'h0064};

  initial begin
    int lat, p0, w0, r0;
    logic [127:0] rw0, rw1, rw2, rx, ry;

    vt[0] = '{1'b0, 1'b0, 10, 1, ra, junk, ra, 4};
    vt[1] = '{1'b0, 1'b1, 20, 2, ra, junk,
              {16'h7000, 16'h0600, 16'h0050, 16'h0004,
               16'h0000, 16'h0000, 16'h1234, 16'h0000}, 6};
    vt[2] = '{1'b1, 1'b0, 0, 1, rb, pb,
              {16'h0000, 16'h0000, 16'h0000, 16'h0030,
               16'h0000, 16'hFFFE, 16'h8000, 16'h0046}, 6};
    vt[3] = '{1'b1, 1'b1, 40, 2, rb, pb,
              {16'h0000, 16'h0000, 16'h0000, 16'h0030,
               16'h0000, 16'h0000, 16'h0000, 16'h0046}, 10};
    vt[4] = '{1'b0, 1'b1, 50, 1,
              {16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'h0000, 16'h8000, 16'h0005, 16'hFFFF}, junk,
              {16'h0000, 16'h0000, 16'h0000, 16'h0000,
               16'h0000, 16'h0000, 16'h0005, 16'h0000}, 4};
    vt[5] = '{1'b0, 1'b0, 60, 0, ra, junk, ra, 2};

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ctl", 128'({busy, done, ofifo_rd, sram_cen, sram_wen}),
        128'(5'b00011));
    chk("rst_addr", 128'(sram_addr), 128'(0));
    chk("rst_d", sram_d, 128'(0));
    @(negedge clk);
    reset = 1'b0;

    // table of single-pattern jobs
    for (int v = 0; v < 6; v++) begin
      for (int r = 0; r < vt[v].len; r++) begin
        poke((vt[v].base + r) % 2048, vt[v].pre);
        push(vt[v].row);
      end
      vgate = 1'b1;
      p0 = pops; w0 = writes; r0 = reads;
      run_job(vt[v].acc, vt[v].relu, vt[v].len, vt[v].base, lat);
      chk($sformatf("v%0d_lat", v), 128'(lat), 128'(vt[v].lat));
      chk($sformatf("v%0d_pops", v), 128'(pops - p0), 128'(vt[v].len));
      chk($sformatf("v%0d_wr", v), 128'(writes - w0), 128'(vt[v].len));
      chk($sformatf("v%0d_rd", v), 128'(reads - r0),
          128'(vt[v].acc ? vt[v].len : 0));
      for (int r = 0; r < vt[v].len; r++)
        chk($sformatf("v%0d_mem%0d", v, r),
            mem[(vt[v].base + r) % 2048], vt[v].exp);
      if (vt[v].len > 0) begin
        chk($sformatf("v%0d_hold", v),
            128'({sram_cen, sram_wen, sram_addr}),
            128'({2'b11, 11'(vt[v].base + vt[v].len - 1)}));
      end
      @(posedge clk); #1;
      chk($sformatf("v%0d_idle", v), 128'({busy, done}), 128'(2'b00));
    end

    // three distinct rows to 5..7
    rw0 = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    rw1 = 128'hFFF0_FFF1_FFF2_FFF3_8001_7FFE_0100_0200;
    rw2 = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    for (int r = 0; r < 3; r++) poke(5 + r, junk);
    push(rw0); push(rw1); push(rw2);
    p0 = pops;
    run_job(1'b0, 1'b0, 3, 5, lat);
    chk("seq3_lat", 128'(lat), 128'(8));
    chk("seq3_pops", 128'(pops - p0), 128'(3));
    chk("seq3_m5", mem[5], rw0);
    chk("seq3_m6", mem[6], rw1);
    chk("seq3_m7", mem[7], rw2);

    // FIFO stalls for 10 cycles; a start during the stall is ignored
    poke(200, junk);
    vgate = 1'b0;
    rx = 128'hCAFE_0001_CAFE_0002_CAFE_0003_CAFE_0004;
    push(rx);
    p0 = pops; w0 = writes;
    @(negedge clk);
    acc = 1'b0; relu = 1'b0; len = 11'd1; base = 11'd100; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      chk($sformatf("stall%0d", k), 128'({busy, ofifo_rd}), 128'(2'b10));
      if (k == 3) begin
        base = 11'd200; len = 11'd0; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
    end
    start = 1'b0;
    vgate = 1'b1;
    #1;
    chk("stall_pop", 128'(ofifo_rd), 128'(1));
    lat = 0;
    while (!done && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("stall_done", 128'(done), 128'(1));
    chk("stall_pops", 128'(pops - p0), 128'(1));
    chk("stall_wr", 128'(writes - w0), 128'(1));
    chk("stall_m100", mem[100], rx);
    chk("stall_m200", mem[200], junk);

    // address wrap past 2047
    rw0 = 128'hA0A0_0000_0000_0000_0000_0000_0000_0001;
    rw1 = 128'hB0B0_0000_0000_0000_0000_0000_0000_0002;
    push(rw0); push(rw1);
    w0 = writes;
    run_job(1'b0, 1'b0, 2, 2047, lat);
    chk("wrap_lat", 128'(lat), 128'(6));
    chk("wrap_a0", 128'(wr_log[w0 % 8]), 128'(2047));
    chk("wrap_a1", 128'(wr_log[(w0 + 1) % 8]), 128'(0));
    chk("wrap_m2047", mem[2047], rw0);
    chk("wrap_m0", mem[0], rw1);

    // reset while waiting for the second row
    ry = 128'h5555_5555_5555_5555_5555_5555_5555_5555;
    rx = 128'h3333_3333_3333_3333_3333_3333_3333_3333;
    push(rx);
    p0 = pops; w0 = writes;
    @(negedge clk);
    acc = 1'b0; relu = 1'b0; len = 11'd2; base = 11'd2047; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = 0;
    while (writes == w0 && lat < 50) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("rst_first_wr", 128'(writes - w0), 128'(1));
    push(ry);
    reset = 1'b1;
    #1;
    chk("rst_no_pop", 128'({ofifo_valid, ofifo_rd}), 128'(2'b10));
    @(posedge clk); #1;
    reset = 1'b0;
    chk("rst_abort", 128'({busy, done, sram_cen, sram_wen}),
        128'(4'b0011));
    @(posedge clk); #1;
    chk("rst_pops", 128'(pops - p0), 128'(1));
    chk("rst_wr", 128'(writes - w0), 128'(1));
    chk("rst_m0", mem[0], rw1);
    chk("rst_m2047", mem[2047], rx);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
